// File: rtl/div_unit_cached_pkg.sv
// Shared constants for the cached divider: FSM encodings, ALU div op codes, pointer sizing.
package div_unit_cached_pkg;

   localparam logic [1:0] DIV_IDLE = 2'd0;
   localparam logic [1:0] DIV_CALC = 2'd1;
   localparam logic [1:0] DIV_DONE = 2'd2;

   localparam logic [1:0] OP_DIV  = 2'd0;
   localparam logic [1:0] OP_MOD  = 2'd1;
   localparam logic [1:0] OP_DIVU = 2'd2;
   localparam logic [1:0] OP_MODU = 2'd3;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/div_hist_cache.sv
// Result-history cache: full-key combinational lookup, round-robin fill, synchronous invalidate-all.
module div_hist_cache
   import div_unit_cached_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int CACHE_DEPTH = 4,
   parameter int KW          = 2*WIDTH+1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inval_i,
   input  logic [KW-1:0]    lkp_key_i,
   output logic             lkp_hit_o,
   output logic [WIDTH-1:0] lkp_quo_o,
   output logic [WIDTH-1:0] lkp_rem_o,
   input  logic             wr_en_i,
   input  logic [KW-1:0]    wr_key_i,
   input  logic [WIDTH-1:0] wr_quo_i,
   input  logic [WIDTH-1:0] wr_rem_i
);

   localparam int PW = ptr_w(CACHE_DEPTH);

   logic [CACHE_DEPTH-1:0] vld_q;
   logic [PW-1:0]          ptr_q;
   logic [KW-1:0]          key_q [CACHE_DEPTH];
   logic [WIDTH-1:0]       quo_q [CACHE_DEPTH];
   logic [WIDTH-1:0]       rem_q [CACHE_DEPTH];
   logic                   wr_go;

   assign wr_go = wr_en_i & ~inval_i;

   // Only misses are written, so at most one entry can match a key.
   always_comb begin
      lkp_hit_o = 1'b0;
      lkp_quo_o = '0;
      lkp_rem_o = '0;
      for (int i = 0; i < CACHE_DEPTH; i++) begin
         if (vld_q[i] && (key_q[i] == lkp_key_i)) begin
            lkp_hit_o = 1'b1;
            lkp_quo_o = quo_q[i];
            lkp_rem_o = rem_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         ptr_q <= '0;
      end else if (inval_i) begin
         vld_q <= '0;
      end else if (wr_en_i) begin
         vld_q[ptr_q] <= 1'b1;
         ptr_q        <= (ptr_q == PW'(CACHE_DEPTH-1)) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_go) begin
         key_q[ptr_q] <= wr_key_i;
         quo_q[ptr_q] <= wr_quo_i;
         rem_q[ptr_q] <= wr_rem_i;
      end
   end

endmodule

// File: rtl/div_unit_cached.sv
// Iterative restoring divider (one quotient bit per cycle) with fast paths and a result-history cache.
module div_unit_cached
   import div_unit_cached_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int CACHE_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [WIDTH-1:0] in_op1,
   input  logic [WIDTH-1:0] in_op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quo,
   output logic [WIDTH-1:0] out_rem,
   output logic             out_hit
);

   localparam int KW = 2*WIDTH+1;
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, prem_q, prem_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             hit_q, hit_d, nq_q, nq_d, nr_q, nr_d;
   logic [KW-1:0]    key_q, key_d, op_key;

   logic             accept, is_ovf, c_hit, qbit, wr_en;
   logic [WIDTH-1:0] mag1, mag2, c_quo, c_rem, q_nxt, r_nxt;
   logic [WIDTH:0]   shifted, trial;

   assign in_ready  = (state_q == DIV_IDLE);
   assign out_valid = (state_q == DIV_DONE);
   assign out_quo   = quo_q;
   assign out_rem   = rem_q;
   assign out_hit   = hit_q;

   assign accept = in_valid & in_ready & ~flush;
   assign op_key = {in_sign, in_op1, in_op2};
   assign is_ovf = in_sign & (in_op1 == MIN_VAL) & (in_op2 == '1);
   assign mag1   = (in_sign & in_op1[WIDTH-1]) ? -in_op1 : in_op1;
   assign mag2   = (in_sign & in_op2[WIDTH-1]) ? -in_op2 : in_op2;

   // The WIDTH+1-bit partial remainder is the shifted value; only its low WIDTH bits survive a step.
   assign shifted = {prem_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};
   assign qbit    = ~trial[WIDTH];
   assign q_nxt   = {dvd_q[WIDTH-2:0], qbit};
   assign r_nxt   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

   assign wr_en = (state_q == DIV_DONE) & out_ready & ~hit_q & ~flush;

   div_hist_cache #(.WIDTH(WIDTH), .CACHE_DEPTH(CACHE_DEPTH), .KW(KW)) u_cache (
      .clk       (clk),
      .rst       (rst),
      .inval_i   (flush),
      .lkp_key_i (op_key),
      .lkp_hit_o (c_hit),
      .lkp_quo_o (c_quo),
      .lkp_rem_o (c_rem),
      .wr_en_i   (wr_en),
      .wr_key_i  (key_q),
      .wr_quo_i  (quo_q),
      .wr_rem_i  (rem_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      hit_d   = hit_q;
      nq_d    = nq_q;
      nr_d    = nr_q;
      key_d   = key_q;
      case (state_q)
         DIV_IDLE: begin
            if (accept) begin
               key_d   = op_key;
               hit_d   = 1'b1;
               state_d = DIV_DONE;
               if (in_op2 == '0) begin
                  quo_d = '1;
                  rem_d = in_op1;
               end else if (in_op1 == '0) begin
                  quo_d = '0;
                  rem_d = '0;
               end else if (is_ovf) begin
                  quo_d = MIN_VAL;
                  rem_d = '0;
               end else if (c_hit) begin
                  quo_d = c_quo;
                  rem_d = c_rem;
               end else begin
                  hit_d   = 1'b0;
                  dvd_d   = mag1;
                  dvs_d   = mag2;
                  prem_d  = '0;
                  cnt_d   = '0;
                  nq_d    = in_sign & (in_op1[WIDTH-1] ^ in_op2[WIDTH-1]);
                  nr_d    = in_sign & in_op1[WIDTH-1];
                  state_d = DIV_CALC;
               end
            end
         end
         DIV_CALC: begin
            dvd_d  = q_nxt;
            prem_d = r_nxt;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               quo_d   = nq_q ? -q_nxt : q_nxt;
               rem_d   = nr_q ? -r_nxt : r_nxt;
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (out_ready) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (flush) state_d = DIV_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         hit_q   <= 1'b0;
         nq_q    <= 1'b0;
         nr_q    <= 1'b0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         hit_q   <= hit_d;
         nq_q    <= nq_d;
         nr_q    <= nr_d;
         key_q   <= key_d;
      end
   end

endmodule

// File: tb/tb_div_unit_cached.sv
// Directed bench for div_unit_cached: latency, fast paths, cache hits/eviction, flush, backpressure.
module tb_div_unit_cached;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_sign, out_valid, out_ready, out_hit;
   logic [31:0] in_op1, in_op2, out_quo, out_rem;
   int          total = 0;
   int          bad   = 0;
   int          lat;
   int          viol;
   logic [31:0] hold_q, hold_r;

   always #5 clk = ~clk;

   div_unit_cached #(.WIDTH(32), .CACHE_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_op1    (in_op1),
      .in_op2    (in_op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_quo   (out_quo),
      .out_rem   (out_rem),
      .out_hit   (out_hit)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request, wait for out_valid; lat = cycles from accept edge to out_valid.
   task automatic req(input logic s, input logic [31:0] a, input logic [31:0] b, output int l);
      @(negedge clk);
      chk("in_ready_before_req", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; in_sign = s; in_op1 = a; in_op2 = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!out_valid && l < 100);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic expect_res(input string tag, input int l, input int le,
                             input logic [31:0] q, input logic [31:0] r, input logic h);
      chk({tag, "_lat"}, l, le);
      chk({tag, "_quo"}, out_quo, q);
      chk({tag, "_rem"}, out_rem, r);
      chk({tag, "_hit"}, {31'b0, out_hit}, {31'b0, h});
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sign = 1'b0;
      in_op1 = '0; in_op2 = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_quo", out_quo, 32'd0);
      chk("rst_rem", out_rem, 32'd0);
      chk("rst_hit", {31'b0, out_hit}, 32'd0);
      rst = 1'b0;

      // 1-2: miss then hit on the same signed key; unsigned key is distinct
      req(1'b1, 32'd100, 32'd7, lat); expect_res("s100d7_miss", lat, 33, 32'd14, 32'd2, 1'b0); take();
      req(1'b1, 32'd100, 32'd7, lat); expect_res("s100d7_hit", lat, 1, 32'd14, 32'd2, 1'b1); take();
      req(1'b0, 32'd100, 32'd7, lat); expect_res("u100d7_miss", lat, 33, 32'd14, 32'd2, 1'b0); take();

      // 3: sign handling
      req(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
      expect_res("sm7d2", lat, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0); take();
      req(1'b0, 32'hFFFF_FFF9, 32'd2, lat);
      expect_res("uF9d2", lat, 33, 32'h7FFF_FFFC, 32'd1, 1'b0); take();

      // 4: fast paths leave the cache alone
      req(1'b0, 32'd5, 32'd0, lat); expect_res("div0", lat, 1, 32'hFFFF_FFFF, 32'd5, 1'b1); take();
      req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      expect_res("ovf", lat, 1, 32'h8000_0000, 32'd0, 1'b0 | 1'b1); take();
      req(1'b1, 32'd0, 32'd9, lat); expect_res("zero_dvd", lat, 1, 32'd0, 32'd0, 1'b1); take();
      req(1'b1, 32'd100, 32'd7, lat); expect_res("s100d7_still", lat, 1, 32'd14, 32'd2, 1'b1); take();

      // 5: cache is full with pointer back at 0; A..E then A again
      req(1'b0, 32'd1000, 32'd3, lat);  expect_res("A", lat, 33, 32'd333, 32'd1, 1'b0); take();
      req(1'b0, 32'd1000, 32'd7, lat);  expect_res("B", lat, 33, 32'd142, 32'd6, 1'b0); take();
      req(1'b0, 32'd1000, 32'd9, lat);  expect_res("C", lat, 33, 32'd111, 32'd1, 1'b0); take();
      req(1'b0, 32'd1000, 32'd11, lat); expect_res("D", lat, 33, 32'd90, 32'd10, 1'b0); take();
      req(1'b0, 32'd1000, 32'd13, lat); expect_res("E", lat, 33, 32'd76, 32'd12, 1'b0); take();
      req(1'b0, 32'd1000, 32'd3, lat);  expect_res("A_again", lat, 33, 32'd333, 32'd1, 1'b0); take();
      req(1'b0, 32'd1000, 32'd9, lat);  expect_res("C_hit", lat, 1, 32'd111, 32'd1, 1'b1); take();
      req(1'b0, 32'd1000, 32'd13, lat); expect_res("E_hit", lat, 1, 32'd76, 32'd12, 1'b1); take();

      // 6a: flush in the middle of CALC
      @(negedge clk);
      in_valid = 1'b1; in_sign = 1'b0; in_op1 = 32'd12345; in_op2 = 32'd17;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
      viol = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) viol++;
      end
      chk("flush_no_valid", viol, 0);
      req(1'b0, 32'd1000, 32'd9, lat);  expect_res("C_after_flush", lat, 33, 32'd111, 32'd1, 1'b0); take();

      // flush beats a same-cycle accept
      @(negedge clk);
      in_valid = 1'b1; in_sign = 1'b0; in_op1 = 32'd5; in_op2 = 32'd0; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      chk("flush_vs_accept_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_vs_accept_ready", {31'b0, in_ready}, 32'd1);
      req(1'b0, 32'd1000, 32'd9, lat);  expect_res("C_after_flush2", lat, 33, 32'd111, 32'd1, 1'b0); take();

      // 6b: backpressure; a competing request must not be taken while DONE
      req(1'b1, 32'd100, 32'hFFFF_FFF9, lat);
      expect_res("s100dm7", lat, 33, 32'hFFFF_FFF2, 32'd2, 1'b0);
      hold_q = out_quo; hold_r = out_rem;
      in_valid = 1'b1; in_sign = 1'b0; in_op1 = 32'd7; in_op2 = 32'd0;
      viol = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!out_valid || in_ready || out_quo !== hold_q || out_rem !== hold_r || out_hit) viol++;
      end
      chk("bp_stable", viol, 0);
      in_valid = 1'b0;
      take();
      @(negedge clk);
      chk("bp_released_ready", {31'b0, in_ready}, 32'd1);
      chk("bp_released_valid", {31'b0, out_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
